reorder_buffer: RTL and testbench
=================================

# reorder_buffer

In-order retirement buffer for the out-of-order core. The issue stage allocates entries in program order. Execution units write results back by tag in any order. The commit stage reads entries back in allocation order, one per cycle, only once each head entry has completed. Depth, data width and register address width come from the global configuration package (ROB_DEPTH = 64, XLEN = 32, REG_ADDR = 5).

## Interface
- ROB_DEPTH, 64, number of entries; power of two
- XLEN, 32, result data width
- REG_ADDR, 5, destination register index width
- ROB_ADDR, $clog2(ROB_DEPTH), tag width (6)
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; synchronous, active-high
- flush_i  in  1  discard all entries
- alloc_valid_i  in  1  issue stage requests one entry
- alloc_dest_i  in  REG_ADDR  destination register of the allocated instruction
- alloc_ready_o  out  1  an entry is free
- alloc_tag_o  out  ROB_ADDR  tag given to the current allocation (tail index)
- wr_valid_i  in  1  execution writeback strobe
- wr_tag_i  in  ROB_ADDR  entry being completed
- wr_result_i  in  XLEN  result value
- wr_exception_i  in  1  instruction raised an exception
- wr_exc_vector_i  in  4  exception vector (0000 divide-by-zero, 0001 illegal memory access)
- commit_valid_o  out  1  head entry is complete and presented
- commit_ready_i  in  1  commit stage accepts the head entry
- commit_dest_o  out  REG_ADDR  head destination register
- commit_result_o  out  XLEN  head result
- commit_exception_o  out  1  head exception flag
- commit_exc_vector_o  out  4  head exception vector
- count_o  out  ROB_ADDR+1  number of occupied entries (0..ROB_DEPTH)

## Operation
- **Storage.** Per entry, flops hold: done, dest, result, exception, vector.
- **Pointers.** head and tail are ROB_ADDR+1 bits wide; the MSB is the wrap bit.
  - Empty: head == tail.
  - Full: low bits are equal and wrap bits differ.
- **Allocate.** alloc_ready_o = !full. An allocation fires when alloc_valid_i && alloc_ready_o. On fire:
  - entry[tail].done <= 0 and entry[tail].dest <= alloc_dest_i;
  - tail increments, wrapping modulo 2*ROB_DEPTH.
  - alloc_tag_o = tail[ROB_ADDR-1:0], valid whenever alloc_ready_o is high.
- **Writeback.** When wr_valid_i is high:
  - entry[wr_tag_i] stores result, exception and vector, and done <= 1.
  - A writeback to an unoccupied slot (not between head and tail) is ignored with no state change.
- **Commit.** commit_valid_o = !empty && entry[head].done.
  - All commit_* data outputs are driven combinationally from entry[head].
  - A commit fires when commit_valid_o && commit_ready_i. On fire, entry[head].done <= 0 and head increments.
  - Holding commit_ready_i low keeps the outputs stable.
- **X0 destination.** When commit_dest_o == X0, commit_result_o is forced to 0.
- **Exceptions.** An exception entry commits like any other entry, with commit_exception_o = 1. The commit stage is responsible for asserting flush_i afterwards.
- **Occupancy.** count_o = tail - head, computed in ROB_ADDR+1-bit arithmetic.
- **Priority.** flush_i takes precedence over alloc, writeback and commit in the same cycle. On flush, head <= 0, tail <= 0 and all done bits clear.
- **Simultaneous events:**
  - Alloc and commit in the same cycle are both performed; count is unchanged.
  - When full, alloc_ready_o stays low even if a commit fires that cycle (no same-cycle bypass).
  - A writeback to the head entry does not make it committable in that same cycle.

## Timing
- **Reset.** rst_i sampled high at a rising edge gives, from the next cycle:
  - head = tail = 0 and all done bits 0;
  - alloc_ready_o = 1, alloc_tag_o = 0, commit_valid_o = 0, count_o = 0;
  - commit data outputs 0.
- **Reset mid-operation.** Same result as flush; any in-flight alloc, writeback or commit in the reset cycle is discarded.
- **Latencies:**
  - Allocation in cycle N: the next tag appears on alloc_tag_o in cycle N+1.
  - Writeback in cycle N: the earliest commit_valid_o for that entry is cycle N+1.
- **Throughput.** One allocation, one writeback and one commit per cycle.

## Test plan
- **Reset then fill.** Reset, then allocate 64 times with dest = i%32 → tags 0..63 in order; count_o = 64, alloc_ready_o = 0; a 65th alloc_valid_i is not accepted.
- **Out-of-order writeback.** Allocate tags 0,1,2; write tag 2 (0xC), then tag 0 (0xA), then tag 1 (0xB) → commits emerge as 0xA, 0xB, 0xC, with commit_valid_o low until tag 0 is written.
- **Wrap-around.** Allocate and commit 100 entries in steady state with 3 in flight → tags wrap 63→0, count_o stays 3, commit order is preserved.
- **Full with simultaneous commit.** At count_o = 64, assert alloc_valid_i and commit_ready_i → the commit fires, the alloc does not, count_o = 63. On the next cycle the alloc fires and receives tag equal to the committed slot.
- **Exception and X0.** Write tag 0 with exception, vector 0001; the entry for tag 1 has dest 0 and result 0xFFFF → commit 0 shows commit_exception_o = 1 and vector 0001; commit 1 shows commit_result_o = 0.
- **Flush priority.** With 10 entries in flight, assert flush_i together with alloc, writeback and commit → the next cycle shows count_o = 0, commit_valid_o = 0, alloc_tag_o = 0.

Source files
------------

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer with out-of-order writeback by tag
module reorder_buffer #(
    parameter int ROB_DEPTH = 64,
    parameter int XLEN      = 32,
    parameter int REG_ADDR  = 5,
    parameter int ROB_ADDR  = $clog2(ROB_DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                alloc_valid_i,
    input  logic [REG_ADDR-1:0] alloc_dest_i,
    output logic                alloc_ready_o,
    output logic [ROB_ADDR-1:0] alloc_tag_o,
    input  logic                wr_valid_i,
    input  logic [ROB_ADDR-1:0] wr_tag_i,
    input  logic [XLEN-1:0]     wr_result_i,
    input  logic                wr_exception_i,
    input  logic [3:0]          wr_exc_vector_i,
    output logic                commit_valid_o,
    input  logic                commit_ready_i,
    output logic [REG_ADDR-1:0] commit_dest_o,
    output logic [XLEN-1:0]     commit_result_o,
    output logic                commit_exception_o,
    output logic [3:0]          commit_exc_vector_o,
    output logic [ROB_ADDR:0]   count_o
);

    logic [ROB_ADDR:0]     head_q, head_d;
    logic [ROB_ADDR:0]     tail_q, tail_d;
    logic [ROB_DEPTH-1:0]  done_q, done_d;
    logic [REG_ADDR-1:0]   dest_q   [ROB_DEPTH];
    logic [REG_ADDR-1:0]   dest_d   [ROB_DEPTH];
    logic [XLEN-1:0]       result_q [ROB_DEPTH];
    logic [XLEN-1:0]       result_d [ROB_DEPTH];
    logic                  exc_q    [ROB_DEPTH];
    logic                  exc_d    [ROB_DEPTH];
    logic [3:0]            vec_q    [ROB_DEPTH];
    logic [3:0]            vec_d    [ROB_DEPTH];

    logic [ROB_ADDR-1:0]   head_idx;
    logic [ROB_ADDR-1:0]   tail_idx;
    logic [ROB_ADDR-1:0]   wr_offset;
    logic                  empty;
    logic                  full;
    logic                  alloc_fire;
    logic                  commit_fire;
    logic                  wr_hit;

    assign head_idx = head_q[ROB_ADDR-1:0];
    assign tail_idx = tail_q[ROB_ADDR-1:0];
    assign empty    = (head_q == tail_q);
    assign full     = (head_idx == tail_idx) && (head_q[ROB_ADDR] != tail_q[ROB_ADDR]);
    assign count_o  = tail_q - head_q;

    // A tag is occupied when its distance from head is below the occupancy.
    assign wr_offset = wr_tag_i - head_idx;
    assign wr_hit    = wr_valid_i && ({1'b0, wr_offset} < count_o);

    assign alloc_ready_o = !full;
    assign alloc_tag_o   = tail_idx;
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;

    assign commit_valid_o      = !empty && done_q[head_idx];
    assign commit_fire         = commit_valid_o && commit_ready_i;
    assign commit_dest_o       = dest_q[head_idx];
    assign commit_result_o     = (commit_dest_o == '0) ? '0 : result_q[head_idx];
    assign commit_exception_o  = exc_q[head_idx];
    assign commit_exc_vector_o = vec_q[head_idx];

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        done_d   = done_q;
        dest_d   = dest_q;
        result_d = result_q;
        exc_d    = exc_q;
        vec_d    = vec_q;
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            done_d = '0;
        end else begin
            if (wr_hit) begin
                result_d[wr_tag_i] = wr_result_i;
                exc_d[wr_tag_i]    = wr_exception_i;
                vec_d[wr_tag_i]    = wr_exc_vector_i;
                done_d[wr_tag_i]   = 1'b1;
            end
            if (commit_fire) begin
                done_d[head_idx] = 1'b0;
                head_d           = head_q + 1'b1;
            end
            if (alloc_fire) begin
                done_d[tail_idx] = 1'b0;
                dest_d[tail_idx] = alloc_dest_i;
                tail_d           = tail_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            done_q <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                dest_q[i]   <= '0;
                result_q[i] <= '0;
                exc_q[i]    <= 1'b0;
                vec_q[i]    <= '0;
            end
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            done_q   <= done_d;
            dest_q   <= dest_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            vec_q    <= vec_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - self-checking bench for reorder_buffer
module tb_reorder_buffer;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        alloc_valid_i = 1'b0;
    logic [4:0]  alloc_dest_i = '0;
    logic        alloc_ready_o;
    logic [5:0]  alloc_tag_o;
    logic        wr_valid_i = 1'b0;
    logic [5:0]  wr_tag_i = '0;
    logic [31:0] wr_result_i = '0;
    logic        wr_exception_i = 1'b0;
    logic [3:0]  wr_exc_vector_i = '0;
    logic        commit_valid_o;
    logic        commit_ready_i = 1'b0;
    logic [4:0]  commit_dest_o;
    logic [31:0] commit_result_o;
    logic        commit_exception_o;
    logic [3:0]  commit_exc_vector_o;
    logic [6:0]  count_o;

    int total = 0;
    int bad   = 0;

    reorder_buffer dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .flush_i             (flush_i),
        .alloc_valid_i       (alloc_valid_i),
        .alloc_dest_i        (alloc_dest_i),
        .alloc_ready_o       (alloc_ready_o),
        .alloc_tag_o         (alloc_tag_o),
        .wr_valid_i          (wr_valid_i),
        .wr_tag_i            (wr_tag_i),
        .wr_result_i         (wr_result_i),
        .wr_exception_i      (wr_exception_i),
        .wr_exc_vector_i     (wr_exc_vector_i),
        .commit_valid_o      (commit_valid_o),
        .commit_ready_i      (commit_ready_i),
        .commit_dest_o       (commit_dest_o),
        .commit_result_o     (commit_result_o),
        .commit_exception_o  (commit_exception_o),
        .commit_exc_vector_o (commit_exc_vector_o),
        .count_o             (count_o)
    );

    always #5 clk = ~clk;

    // Reference model: program-ordered list of in-flight instructions.
    typedef struct {
        int          tag;
        logic [4:0]  dest;
        bit          done;
        logic [31:0] result;
        bit          exc;
        logic [3:0]  vec;
    } ent_t;

    ent_t mq[$];
    int   next_tag = 0;

    typedef struct {
        bit          av;
        logic [4:0]  dest;
        bit          wv;
        logic [5:0]  wtag;
        logic [31:0] wres;
        bit          cr;
        bit          fl;
        int          e_count;
        bit          e_cv;
        int          e_tag;
        logic [31:0] e_res;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        bit m_valid;
        m_valid = (mq.size() > 0) && mq[0].done;
        check("m_count", count_o, mq.size());
        check("m_ready", alloc_ready_o, mq.size() < DEPTH);
        if (mq.size() < DEPTH) check("m_tag", alloc_tag_o, next_tag);
        check("m_cvalid", commit_valid_o, m_valid);
        if (m_valid) begin
            check("m_cdest", commit_dest_o, mq[0].dest);
            check("m_cresult", commit_result_o, (mq[0].dest == 0) ? 32'd0 : mq[0].result);
            check("m_cexc", commit_exception_o, mq[0].exc);
            check("m_cvec", commit_exc_vector_o, mq[0].vec);
        end
    endtask

    task automatic model_step();
        bit a_fire;
        bit c_fire;
        ent_t e;
        if (rst_i || flush_i) begin
            mq.delete();
            next_tag = 0;
            return;
        end
        a_fire = alloc_valid_i && (mq.size() < DEPTH);
        c_fire = commit_ready_i && (mq.size() > 0) && mq[0].done;
        if (wr_valid_i) begin
            foreach (mq[i]) begin
                if (mq[i].tag == int'(wr_tag_i)) begin
                    mq[i].done   = 1'b1;
                    mq[i].result = wr_result_i;
                    mq[i].exc    = wr_exception_i;
                    mq[i].vec    = wr_exc_vector_i;
                end
            end
        end
        if (c_fire) void'(mq.pop_front());
        if (a_fire) begin
            e.tag = next_tag; e.dest = alloc_dest_i; e.done = 1'b0;
            e.result = '0; e.exc = 1'b0; e.vec = '0;
            mq.push_back(e);
            next_tag = (next_tag + 1) % DEPTH;
        end
    endtask

    task automatic cycle();
        if (!rst_i) check_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst_i = 1'b0; flush_i = 1'b0; alloc_valid_i = 1'b0; alloc_dest_i = '0;
        wr_valid_i = 1'b0; wr_tag_i = '0; wr_result_i = '0; wr_exception_i = 1'b0;
        wr_exc_vector_i = '0; commit_ready_i = 1'b0;
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_ready"}, alloc_ready_o, 1);
        check({pfx, "_tag"}, alloc_tag_o, 0);
        check({pfx, "_cvalid"}, commit_valid_o, 0);
        check({pfx, "_count"}, count_o, 0);
        check({pfx, "_cdest"}, commit_dest_o, 0);
        check({pfx, "_cresult"}, commit_result_o, 0);
        check({pfx, "_cexc"}, commit_exception_o, 0);
        check({pfx, "_cvec"}, commit_exc_vector_o, 0);
    endtask

    initial begin
        // Reset
        idle();
        rst_i = 1'b1;
        cycle();
        idle();
        check_reset_state("rst");

        // Out-of-order writeback, then flush beating an alloc
        tbl.push_back('{1, 5'd1, 0, 6'd0, 32'h0, 0, 0, 1, 0, 1, 32'h0});
        tbl.push_back('{1, 5'd2, 0, 6'd0, 32'h0, 0, 0, 2, 0, 2, 32'h0});
        tbl.push_back('{1, 5'd3, 0, 6'd0, 32'h0, 0, 0, 3, 0, 3, 32'h0});
        tbl.push_back('{0, 5'd0, 1, 6'd2, 32'hC, 0, 0, 3, 0, 3, 32'h0});
        tbl.push_back('{0, 5'd0, 1, 6'd0, 32'hA, 0, 0, 3, 1, 3, 32'hA});
        tbl.push_back('{0, 5'd0, 1, 6'd1, 32'hB, 1, 0, 2, 1, 3, 32'hB});
        tbl.push_back('{0, 5'd0, 0, 6'd0, 32'h0, 1, 0, 1, 1, 3, 32'hC});
        tbl.push_back('{0, 5'd0, 0, 6'd0, 32'h0, 1, 0, 0, 0, 3, 32'h0});
        tbl.push_back('{1, 5'd4, 0, 6'd0, 32'h0, 0, 1, 0, 0, 0, 32'h0});
        foreach (tbl[r]) begin
            idle();
            alloc_valid_i = tbl[r].av; alloc_dest_i = tbl[r].dest;
            wr_valid_i = tbl[r].wv; wr_tag_i = tbl[r].wtag; wr_result_i = tbl[r].wres;
            commit_ready_i = tbl[r].cr; flush_i = tbl[r].fl;
            cycle();
            check($sformatf("tbl%0d_count", r), count_o, tbl[r].e_count);
            check($sformatf("tbl%0d_cvalid", r), commit_valid_o, tbl[r].e_cv);
            check($sformatf("tbl%0d_tag", r), alloc_tag_o, tbl[r].e_tag);
            if (tbl[r].e_cv) check($sformatf("tbl%0d_cresult", r), commit_result_o, tbl[r].e_res);
        end
        idle();

        // Fill to full
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_tag", alloc_tag_o, i);
            alloc_valid_i = 1'b1; alloc_dest_i = 5'(i % 32);
            cycle();
        end
        check("full_count", count_o, 64);
        check("full_ready", alloc_ready_o, 0);
        cycle();
        check("full_reject_count", count_o, 64);
        idle();

        // Full with simultaneous commit: commit fires, alloc waits a cycle
        wr_valid_i = 1'b1; wr_tag_i = 6'd0; wr_result_i = 32'h55;
        cycle();
        idle();
        alloc_valid_i = 1'b1; alloc_dest_i = 5'd9; commit_ready_i = 1'b1;
        cycle();
        check("fullc_count", count_o, 63);
        check("fullc_ready", alloc_ready_o, 1);
        check("fullc_tag", alloc_tag_o, 0);
        commit_ready_i = 1'b0;
        cycle();
        check("fullc_refill", count_o, 64);

        // Reset in the middle of traffic
        idle();
        rst_i = 1'b1; alloc_valid_i = 1'b1; wr_valid_i = 1'b1; wr_tag_i = 6'd5; commit_ready_i = 1'b1;
        cycle();
        idle();
        check_reset_state("mrst");

        // Flush priority with 10 in flight
        for (int i = 0; i < 10; i++) begin
            alloc_valid_i = 1'b1; alloc_dest_i = 5'd7;
            cycle();
        end
        idle();
        wr_valid_i = 1'b1; wr_tag_i = 6'd0; wr_result_i = 32'h77;
        cycle();
        check("fl_pre_cvalid", commit_valid_o, 1);
        flush_i = 1'b1; alloc_valid_i = 1'b1; wr_valid_i = 1'b1; wr_tag_i = 6'd1; commit_ready_i = 1'b1;
        cycle();
        idle();
        check("fl_count", count_o, 0);
        check("fl_cvalid", commit_valid_o, 0);
        check("fl_tag", alloc_tag_o, 0);

        // Exception and X0 destination
        alloc_valid_i = 1'b1; alloc_dest_i = 5'd5; cycle();
        alloc_dest_i = 5'd0; cycle();
        idle();
        wr_valid_i = 1'b1; wr_tag_i = 6'd1; wr_result_i = 32'hFFFF; cycle();
        wr_tag_i = 6'd0; wr_result_i = 32'h1234; wr_exception_i = 1'b1; wr_exc_vector_i = 4'b0001; cycle();
        idle();
        cycle();
        check("exc_cvalid", commit_valid_o, 1);
        check("exc_flag", commit_exception_o, 1);
        check("exc_vec", commit_exc_vector_o, 4'b0001);
        check("exc_dest", commit_dest_o, 5);
        commit_ready_i = 1'b1; cycle();
        check("x0_cvalid", commit_valid_o, 1);
        check("x0_dest", commit_dest_o, 0);
        check("x0_result", commit_result_o, 0);
        check("x0_exc", commit_exception_o, 0);
        cycle();
        check("x0_count", count_o, 0);
        idle();

        // Writeback to head is not committable in the same cycle
        alloc_valid_i = 1'b1; alloc_dest_i = 5'd9; cycle();
        idle();
        wr_valid_i = 1'b1; wr_tag_i = 6'd2; wr_result_i = 32'h99; commit_ready_i = 1'b1;
        #1;
        check("wbh_same_cvalid", commit_valid_o, 0);
        cycle();
        check("wbh_next_cvalid", commit_valid_o, 1);
        check("wbh_count", count_o, 1);
        idle();
        flush_i = 1'b1; cycle();
        idle();

        // Steady-state wrap-around with three in flight
        alloc_valid_i = 1'b1; alloc_dest_i = 5'd1; cycle();
        alloc_dest_i = 5'd2; wr_valid_i = 1'b1; wr_tag_i = 6'd0; wr_result_i = 32'd0; cycle();
        alloc_dest_i = 5'd3; wr_tag_i = 6'd1; wr_result_i = 32'd1; cycle();
        for (int k = 0; k < 100; k++) begin
            alloc_valid_i = 1'b1; alloc_dest_i = 5'(((k + 3) % 31) + 1);
            wr_valid_i = 1'b1; wr_tag_i = 6'((k + 2) % DEPTH); wr_result_i = 32'(k + 2);
            commit_ready_i = 1'b1;
            check("wrap_cresult", commit_result_o, k);
            cycle();
            check("wrap_count", count_o, 3);
        end
        idle();

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            idle();
            flush_i = ($urandom_range(0, 99) == 0);
            alloc_valid_i = $urandom_range(0, 1);
            alloc_dest_i = 5'($urandom);
            wr_valid_i = ($urandom_range(0, 3) != 0);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                wr_tag_i = 6'(mq[$urandom_range(0, mq.size() - 1)].tag);
            else
                wr_tag_i = 6'($urandom);
            wr_result_i = $urandom;
            wr_exception_i = ($urandom_range(0, 7) == 0);
            wr_exc_vector_i = 4'($urandom_range(0, 1));
            commit_ready_i = ($urandom_range(0, 3) != 0);
            cycle();
        end
        idle();
        check_model();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
